i2s_serf: RTL and testbench
===========================

I2S_SERF -- requirements
Module: i2s_serf

Interface
REQ-001 Parameter DATA_W, default 24: audio sample width in bits.
REQ-002 Parameter SLOT_W, default 32: sclk periods per channel slot.
REQ-003 clk  input  1  system clock; single clock domain for all logic.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 I2S_sclk  input  1  bit clock from the RN52, asynchronous to clk, at most clk/8.
REQ-006 I2S_ws  input  1  word select; 0 = left slot, 1 = right slot; changes on I2S_sclk fall.
REQ-007 I2S_data  input  1  serial data, MSB first; changes on I2S_sclk fall.
REQ-008 lft_chnnl  output  DATA_W  last complete left sample, two's complement.
REQ-009 rght_chnnl  output  DATA_W  last complete right sample, two's complement.
REQ-010 vld  output  1  one-clk pulse when a new left/right pair is presented.

Function
REQ-011 I2S_sclk, I2S_ws and I2S_data SHALL each pass through a 2-flop synchronizer plus one history flop.
REQ-012 An sclk rise SHALL be detected as synchronized sclk = 1 while its history flop = 0; all sampling uses this single-clk strobe.
REQ-013 ws and data SHALL be taken from the same synchronizer stage at the rise strobe.
REQ-014 FSM states: SYNC, LEFT, RIGHT.
REQ-015 SYNC: on a rise strobe where sampled ws = 0 and previous sampled ws = 1, go to LEFT and clear the bit counter. This is edge E0.
REQ-016 The bit counter (5 bits for SLOT_W = 32) SHALL increment on every rise strobe in LEFT/RIGHT and wrap 31 -> 0.
REQ-017 LEFT: shift I2S_data into the left shift register on rise edges E1..E_DATA_W (counter 1..24); ignore padding bits 25..31.
REQ-018 LEFT -> RIGHT: ws = 1 sampled at counter wrap to 0 (E32). Bits E33..E56 are shifted into the right register.
REQ-019 RIGHT -> LEFT: ws = 0 sampled at counter wrap. The right slot is complete.
REQ-020 On the 24th right-bit strobe, both shift registers SHALL be copied to lft_chnnl and rght_chnnl. vld SHALL be asserted on the next clk for exactly one clk.
REQ-021 A ws change at any counter value other than wrap, or no change at wrap, SHALL force SYNC. No vld is issued; outputs hold.
REQ-022 Data shifted before the first valid E0 SHALL never reach the outputs.
REQ-023 lft_chnnl and rght_chnnl SHALL change only when vld is asserted and hold between pulses.
REQ-024 If sclk stops, the FSM SHALL hold its state. It resumes counting on the next rise, with no timeout.

Reset
REQ-025 Asserting rst_n low SHALL drive the FSM to SYNC and clear the counter and shift registers, asynchronously.
REQ-026 Reset SHALL force lft_chnnl = 0, rght_chnnl = 0 and vld = 0; synchronizer flops reset to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first vld after release requires a new E0.

Structure
REQ-028 A shared package SHALL hold the state enum (SYNC/LEFT/RIGHT) plus the DATA_W and SLOT_W defaults, also used by the downstream filter banks.
REQ-029 The 3-flop synchronizer/edge-detect SHALL be a sub-module, sync_edge, instantiated for sclk, ws and data.

Verification
REQ-030 Reset, then frames with left = 24'h7FFFFF and right = 24'h800000 -> first vld only after a full frame following E0; outputs equal those values.
REQ-031 Stream from the RN52 model at its nominal rate -> exactly one vld per 64 sclk periods; successive samples match the model's table.
REQ-032 Start the bench mid-right-slot -> no vld until a ws fall is seen; first output pair is the complete next frame.
REQ-033 Toggle ws at bit 17 of a left slot -> FSM to SYNC, no vld for that frame, outputs keep the previous values, relock on the next frame.
REQ-034 Assert rst_n low at bit 10 of a right slot -> outputs 0 and vld 0 immediately; the next pair is correct after relock.
REQ-035 Left = 24'hA5A5A5, right = 24'h5A5A5A with garbage in padding bits 25..31 -> outputs are exactly those values, unaffected by the padding.

Source files
------------

// File: rtl/i2s_serf_pkg.sv
// Shared I2S receive definitions: FSM states and default sample/slot geometry.
// The downstream filter banks import the same defaults.
`timescale 1ns/1ps
package i2s_serf_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;

endpackage

// File: rtl/i2s_serf_sync_edge.sv
// Two-flop synchronizer plus one history flop; rise_o is a single-clk strobe
// marking a 0->1 transition of the synchronized input.
`timescale 1ns/1ps
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], d_i};
  end

  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/i2s_serf.sv
// I2S receiver: locks on the ws fall, shifts DATA_W MSB-first bits per slot and
// presents each left/right pair with a one-clk vld pulse.
`timescale 1ns/1ps
module i2s_serf
  import i2s_serf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I2S_sclk,
  input  logic              I2S_ws,
  input  logic              I2S_data,
  output logic [DATA_W-1:0] lft_chnnl,
  output logic [DATA_W-1:0] rght_chnnl,
  output logic              vld
);

  localparam int CNT_W = $clog2(SLOT_W);

  logic sclk_s, rise, ws_s, dat_s, ws_rise, dat_rise;
  logic unused_edges;

  sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d_i(I2S_sclk), .sync_o(sclk_s), .rise_o(rise));
  sync_edge u_ws   (.clk(clk), .rst_n(rst_n), .d_i(I2S_ws),   .sync_o(ws_s),   .rise_o(ws_rise));
  sync_edge u_dat  (.clk(clk), .rst_n(rst_n), .d_i(I2S_data), .sync_o(dat_s),  .rise_o(dat_rise));

  assign unused_edges = sclk_s ^ ws_rise ^ dat_rise;

  i2s_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] shl_q, shl_d, shr_q, shr_d;
  logic [DATA_W-1:0] lft_q, rght_q;
  logic              wsp_q, wsp_d, vld_q, load, in_data;

  assign cnt_inc = cnt_q + 1'b1;
  assign in_data = (cnt_inc != '0) && (int'(cnt_inc) <= DATA_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    wsp_d   = wsp_q;
    load    = 1'b0;
    if (rise) begin
      wsp_d = ws_s;
      case (state_q)
        SYNC: if (!ws_s && wsp_q) begin
          state_d = LEFT;
          cnt_d   = '0;
        end
        LEFT, RIGHT: begin
          cnt_d = cnt_inc;
          // ws may only move exactly at the slot boundary; anything else drops lock
          if (cnt_inc == '0) begin
            if      (state_q == LEFT  &&  ws_s && !wsp_q) state_d = RIGHT;
            else if (state_q == RIGHT && !ws_s &&  wsp_q) state_d = LEFT;
            else                                          state_d = SYNC;
          end else if (ws_s != wsp_q) begin
            state_d = SYNC;
          end else if (in_data) begin
            if (state_q == LEFT) begin
              shl_d = {shl_q[DATA_W-2:0], dat_s};
            end else begin
              shr_d = {shr_q[DATA_W-2:0], dat_s};
              load  = (int'(cnt_inc) == DATA_W);
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      shl_q   <= '0;
      shr_q   <= '0;
      wsp_q   <= 1'b0;
      lft_q   <= '0;
      rght_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      wsp_q   <= wsp_d;
      vld_q   <= load;
      if (load) begin
        lft_q  <= shl_q;
        rght_q <= shr_d;
      end
    end
  end

  assign lft_chnnl  = lft_q;
  assign rght_chnnl = rght_q;
  assign vld        = vld_q;

endmodule

// File: tb/tb_i2s_serf.sv
// Self-checking bench for i2s_serf: an RN52-style serializer feeds frames and a
// scoreboard queue holds the pairs that must appear on each vld pulse.
`timescale 1ns/1ps
module tb_i2s_serf;

  localparam int DW = 24;
  localparam int SW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sclk = 1'b0, ws = 1'b0, dat = 1'b0;
  logic [DW-1:0] lft, rght;
  logic vld;

  int total = 0, bad = 0, vld_cnt = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_exp;
  logic vld_prev = 1'b0;

  always #5 clk = ~clk;

  i2s_serf #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .I2S_sclk(sclk), .I2S_ws(ws), .I2S_data(dat),
    .lft_chnnl(lft), .rght_chnnl(rght), .vld(vld)
  );

  // Scoreboard side: every vld pulse pops one expected pair.
  always @(negedge clk) begin
    if (vld) begin
      vld_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_vld got lft=%h rght=%h required no vld", lft, rght);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({lft, rght} !== mon_exp) begin
          bad++;
          $display("FAIL pair got lft=%h rght=%h required lft=%h rght=%h",
                   lft, rght, mon_exp[2*DW-1:DW], mon_exp[DW-1:0]);
        end
      end
      if (vld_prev) begin
        total++;
        bad++;
        $display("FAIL vld_width got 2+ cycles required 1");
      end
    end
    vld_prev <= vld;
  end

  task automatic send_bit(input logic w, input logic d);
    sclk = 1'b0; ws = w; dat = d;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Bit p of a slot is sampled on rise E_p; data bits sit at p = 1..DW, rest is garbage.
  task automatic send_slot(input logic w, input logic [DW-1:0] word, input int nbits, input int flip_at);
    logic d, wv;
    for (int p = 0; p < nbits; p++) begin
      d  = (p >= 1 && p <= DW) ? word[DW-p] : 1'($urandom_range(1));
      wv = (flip_at >= 0 && p >= flip_at) ? ~w : w;
      send_bit(wv, d);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic expect_out);
    if (expect_out) exp_q.push_back({l, r});
    send_slot(1'b0, l, SW, -1);
    send_slot(1'b1, r, SW, -1);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending got %0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sclk = 1'b0; ws = 1'b0; dat = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 3;
    if (lft  !== '0)   begin bad++; $display("FAIL reset_lft got %h required 0", lft); end
    if (rght !== '0)   begin bad++; $display("FAIL reset_rght got %h required 0", rght); end
    if (vld  !== 1'b0) begin bad++; $display("FAIL reset_vld got %b required 0", vld); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_scale();
    int vc;
    send_slot(1'b1, 24'h123456, SW, -1);
    vc = vld_cnt;
    exp_q.push_back({24'h7FFFFF, 24'h800000});
    send_slot(1'b0, 24'h7FFFFF, SW, -1);
    total++;
    if (vld_cnt != vc) begin bad++; $display("FAIL early_vld got %0d required 0", vld_cnt - vc); end
    send_slot(1'b1, 24'h800000, SW, -1);
    send_frame(24'h7FFFFF, 24'h800000, 1'b1);
    check_drained("full_scale");
  endtask

  task automatic test_stream();
    logic [DW-1:0] tl[6] = '{24'h000001, 24'hFFFFFF, 24'h3C0FF0, 24'h800001, 24'h0F0F0F, 24'h7FFFFE};
    logic [DW-1:0] tr[6] = '{24'hFFFFFE, 24'h000000, 24'hC3F00F, 24'h7FFFFF, 24'hF0F0F0, 24'h555555};
    int vc;
    vc = vld_cnt;
    for (int i = 0; i < 6; i++) send_frame(tl[i], tr[i], 1'b1);
    check_drained("stream");
    total++;
    if (vld_cnt - vc != 6) begin bad++; $display("FAIL stream_vld_count got %0d required 6", vld_cnt - vc); end
  endtask

  task automatic test_mid_right();
    int vc;
    do_reset();
    vc = vld_cnt;
    send_slot(1'b1, 24'hDEADBE, 10, -1);
    total++;
    if (vld_cnt != vc) begin bad++; $display("FAIL mid_right_vld got %0d required 0", vld_cnt - vc); end
    send_frame(24'h246801, 24'h13579B, 1'b1);
    send_frame(24'h0ABCDE, 24'hF12345, 1'b1);
    check_drained("mid_right");
  endtask

  task automatic test_ws_glitch();
    send_frame(24'h111111, 24'h222222, 1'b1);
    send_slot(1'b0, 24'h333333, SW, 17);
    send_slot(1'b1, 24'h444444, SW, -1);
    check_drained("ws_glitch");
    total += 2;
    if (lft  !== 24'h111111) begin bad++; $display("FAIL glitch_hold_lft got %h required 111111", lft); end
    if (rght !== 24'h222222) begin bad++; $display("FAIL glitch_hold_rght got %h required 222222", rght); end
    send_frame(24'h555555, 24'h666666, 1'b1);
    check_drained("ws_relock");
  endtask

  task automatic test_reset_mid();
    send_frame(24'h777777, 24'h888888, 1'b1);
    send_slot(1'b0, 24'h999999, SW, -1);
    send_slot(1'b1, 24'hAAAAAA, 10, -1);
    rst_n = 1'b0;
    #1;
    total += 3;
    if (lft  !== '0)   begin bad++; $display("FAIL midrst_lft got %h required 0", lft); end
    if (rght !== '0)   begin bad++; $display("FAIL midrst_rght got %h required 0", rght); end
    if (vld  !== 1'b0) begin bad++; $display("FAIL midrst_vld got %b required 0", vld); end
    check_drained("midrst_partial");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_slot(1'b1, 24'hBBBBBB, SW, -1);
    send_frame(24'hCCCCCC, 24'hDDDDDD, 1'b1);
    check_drained("midrst_relock");
  endtask

  task automatic test_padding();
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    check_drained("padding");
    total += 2;
    if (lft  !== 24'hA5A5A5) begin bad++; $display("FAIL pad_lft got %h required a5a5a5", lft); end
    if (rght !== 24'h5A5A5A) begin bad++; $display("FAIL pad_rght got %h required 5a5a5a", rght); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_stream();
    test_mid_right();
    test_ws_glitch();
    test_reset_mid();
    test_padding();
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
